// File: rtl/data_mem_responder.sv
// Word-addressed 32-bit data memory responder. After reset the array is
// zero-filled one word per cycle; accesses are accepted only once ready.
module data_mem_responder #(
  parameter int DEPTH = 128,
  parameter int AW    = 7,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          CEN,
  input  logic          WEN,
  input  logic          OEN,
  input  logic [AW-1:0] A,
  input  logic [31:0]   Data2Mem,
  output logic [31:0]   ReadDataMem,
  output logic          ready,
  output logic [CW-1:0] rd_cnt,
  output logic [CW-1:0] wr_cnt
);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  logic [31:0]   mem_r [DEPTH];
  state_t        state_r;
  logic [AW-1:0] clr_ptr_r;
  logic          ready_r;
  logic [CW-1:0] rd_cnt_r;
  logic [CW-1:0] wr_cnt_r;

  logic          rd_acc_s;
  logic          wr_acc_s;
  logic          mem_we_s;
  logic [AW-1:0] mem_wa_s;
  logic [31:0]   mem_wd_s;
  logic [31:0]   rd_data_s;

  // Decode accepted accesses; nothing is accepted until the clear has finished.
  always_comb begin
    rd_acc_s = 1'b0;
    wr_acc_s = 1'b0;
    if (ready_r && !CEN) begin
      rd_acc_s = WEN;
      wr_acc_s = !WEN;
    end else begin
      rd_acc_s = 1'b0;
      wr_acc_s = 1'b0;
    end
  end

  // Single array write port shared between the clear sweep and user writes.
  always_comb begin
    mem_we_s = 1'b0;
    mem_wa_s = clr_ptr_r;
    mem_wd_s = 32'h0;
    if (!rst_n) begin
      mem_we_s = 1'b0;
    end else if (state_r == CLEAR) begin
      mem_we_s = 1'b1;
      mem_wa_s = clr_ptr_r;
      mem_wd_s = 32'h0;
    end else if (wr_acc_s) begin
      mem_we_s = 1'b1;
      mem_wa_s = A;
      mem_wd_s = Data2Mem;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Array storage; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_wa_s] <= mem_wd_s;
    end
  end

  // CLEAR/READY sequencer with registered ready flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= CLEAR;
      clr_ptr_r <= {AW{1'b0}};
      ready_r   <= 1'b0;
    end else begin
      case (state_r)
        CLEAR: begin
          clr_ptr_r <= clr_ptr_r + PTR_ONE;
          if (clr_ptr_r == LAST_ADDR) begin
            state_r <= READY;
            ready_r <= 1'b1;
          end else begin
            state_r <= CLEAR;
            ready_r <= 1'b0;
          end
        end
        READY: begin
          state_r <= READY;
          ready_r <= 1'b1;
        end
        default: begin
          state_r   <= CLEAR;
          clr_ptr_r <= {AW{1'b0}};
          ready_r   <= 1'b0;
        end
      endcase
    end
  end

  // Saturating access counters; OEN does not gate the read count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt_r <= {CW{1'b0}};
      wr_cnt_r <= {CW{1'b0}};
    end else begin
      if (rd_acc_s && (rd_cnt_r != CNT_MAX)) begin
        rd_cnt_r <= rd_cnt_r + CNT_ONE;
      end
      if (wr_acc_s && (wr_cnt_r != CNT_MAX)) begin
        wr_cnt_r <= wr_cnt_r + CNT_ONE;
      end
    end
  end

  // Combinational read; a same-cycle write is not forwarded, so old data is returned.
  always_comb begin
    rd_data_s = 32'h0;
    if (rd_acc_s && !OEN) begin
      rd_data_s = mem_r[A];
    end else begin
      rd_data_s = 32'h0;
    end
  end

  assign ReadDataMem = rd_data_s;
  assign ready       = ready_r;
  assign rd_cnt      = rd_cnt_r;
  assign wr_cnt      = wr_cnt_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised and directed checks of data_mem_responder against a
// cycle-level reference model of the memory, clear timer and counters.
module tb_data_mem_responder;

  localparam int DEPTH = 128;

  logic        clk;
  logic        rst_n;
  logic        cen;
  logic        wen;
  logic        oen;
  logic [6:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  int          m_clr;
  bit          m_ready;
  int          m_rd;
  int          m_wr;
  bit          m_valid = 1'b0;

  data_mem_responder #(.DEPTH(DEPTH), .AW(7), .CW(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .CEN        (cen),
    .WEN        (wen),
    .OEN        (oen),
    .A          (addr),
    .Data2Mem   (wdata),
    .ReadDataMem(rdata),
    .ready      (ready),
    .rd_cnt     (rd_cnt),
    .wr_cnt     (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, compare outputs at the falling edge, advance model at the rising edge.
  task automatic step(input logic r, input logic c, input logic w, input logic o,
                      input logic [6:0] a, input logic [31:0] d);
    logic [31:0] exp_rd;
    rst_n = r; cen = c; wen = w; oen = o; addr = a; wdata = d;
    @(negedge clk);
    if (m_valid) begin
      exp_rd = (m_ready && !c && w && !o) ? m_mem[a] : 32'h0;
      check("ready",  {31'h0, ready}, {31'h0, m_ready});
      check("rdata",  rdata, exp_rd);
      check("rd_cnt", {16'h0, rd_cnt}, 32'(m_rd));
      check("wr_cnt", {16'h0, wr_cnt}, 32'(m_wr));
    end
    @(posedge clk);
    if (!r) begin
      m_clr = 0; m_ready = 1'b0; m_rd = 0; m_wr = 0; m_valid = 1'b1;
    end else if (!m_ready) begin
      m_clr++;
      if (m_clr == DEPTH) begin
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
      end
    end else if (!c) begin
      if (!w) begin
        m_mem[a] = d;
        if (m_wr < 65535) m_wr++;
      end else begin
        if (m_rd < 65535) m_rd++;
      end
    end
    #1;
  endtask

  task automatic wait_ready(input string tag, input int exp_len);
    int n;
    n = 0;
    while (!ready && n < 300) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 7'd0, 32'h0);
      n++;
    end
    check(tag, 32'(n), 32'(exp_len));
  endtask

  initial begin
    int n;
    rst_n = 1'b0; cen = 1'b1; wen = 1'b1; oen = 1'b1; addr = 7'd0; wdata = 32'h0;
    @(posedge clk); #1;
    step(1'b0, 1'b1, 1'b1, 1'b1, 7'd0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 7'd0, 32'h0);

    // Clear timing, then every address reads zero
    wait_ready("clear_len", DEPTH);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 7'(i), 32'h0);

    // Reset in READY re-clears; a write at clear cycle 3 is ignored
    step(1'b0, 1'b1, 1'b1, 1'b1, 7'd0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 7'd0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 7'd127, 32'hFFFF_FFFF);
    wait_ready("reclear_len", DEPTH - 4);
    check("wr_cnt_clear", {16'h0, wr_cnt}, 32'h0);

    // Write then read with OEN low and high
    step(1'b1, 1'b0, 1'b0, 1'b1, 7'd5, 32'hDEADBEEF);
    cen = 1'b0; wen = 1'b1; oen = 1'b0; addr = 7'd5; #1;
    check("rd_oen0", rdata, 32'hDEADBEEF);
    step(1'b1, 1'b0, 1'b1, 1'b0, 7'd5, 32'h0);
    oen = 1'b1; #1;
    check("rd_oen1", rdata, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 7'd5, 32'h0);
    check("wr_cnt_1", {16'h0, wr_cnt}, 32'd1);
    check("rd_cnt_2", {16'h0, rd_cnt}, 32'd2);
    cen = 1'b0; wen = 1'b1; oen = 1'b0; addr = 7'd127; #1;
    check("rd_127", rdata, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 7'd127, 32'h0);

    // Read before a write returns old data; new value next cycle
    step(1'b1, 1'b0, 1'b0, 1'b1, 7'd9, 32'h1);
    cen = 1'b0; wen = 1'b1; oen = 1'b0; addr = 7'd9; #1;
    check("haz_old", rdata, 32'h1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 7'd9, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 7'd9, 32'h2);
    cen = 1'b0; wen = 1'b1; oen = 1'b0; addr = 7'd9; #1;
    check("haz_new", rdata, 32'h2);
    step(1'b1, 1'b0, 1'b1, 1'b0, 7'd9, 32'h0);

    // Random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
           7'($urandom_range(0, 127)), $urandom);
    end

    // Reset at clear cycle 60 restarts the full clear
    step(1'b0, 1'b1, 1'b1, 1'b1, 7'd0, 32'h0);
    for (int i = 0; i < 60; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
           7'($urandom_range(0, 127)), $urandom);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 7'd0, 32'h0);
    wait_ready("midclr_len", DEPTH);

    // Read counter saturation
    for (int i = 0; i < 65540; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), 32'h0);
    end
    check("rd_sat", {16'h0, rd_cnt}, 32'h0000_FFFF);
    n = 0;
    while (n < 3) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, 7'd0, 32'h0);
      n++;
    end
    check("rd_sat_hold", {16'h0, rd_cnt}, 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
